// File: rtl/trees_pkg.sv
// -----------------------------------------------------------------------------
// trees_pkg
//   Shared types and sizing helpers for the trees burst driver.
//   - state_t        : job sequencing states
//   - half_n_feature : 64-bit words per sample (two 32-bit features per word)
//   - len_w          : width of a sample count / prediction index
//   - faddr_w        : width of a feature word address
//   - cnt_w          : width of the feature word counter (one extra bit so a
//                      full job's word count never wraps)
//   - tmo_w          : width of the WAIT_DONE timeout counter
// -----------------------------------------------------------------------------
package trees_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      START     = 3'd2,
      WAIT_DONE = 3'd3,
      DRAIN     = 3'd4
   } state_t;

   function automatic int half_n_feature(input int n_feature);
      return n_feature / 2;
   endfunction

   function automatic int len_w(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

   function automatic int faddr_w(input int max_burst, input int n_feature);
      int w;
      w = $clog2(max_burst * n_feature / 2);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int cnt_w(input int max_burst, input int n_feature);
      return faddr_w(max_burst, n_feature) + 1;
   endfunction

   function automatic int tmo_w(input int timeout_cycles);
      int w;
      w = $clog2(timeout_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/trees_out_skid.sv
// -----------------------------------------------------------------------------
// trees_out_skid
//   Single-entry valid/ready output register. A new word is taken whenever the
//   register is empty or its current word is being accepted downstream, so the
//   stream runs at full rate and holds data/valid steady while stalled.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     clear               synchronous flush (drops out_valid)
//     in_valid/in_ready   upstream handshake, in_data word
//     out_valid/out_ready downstream handshake, out_data word
// -----------------------------------------------------------------------------
module trees_out_skid #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         valid_reg;
   logic [W-1:0] data_reg;

   assign in_ready  = !valid_reg || out_ready;
   assign out_valid = valid_reg;
   assign out_data  = data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (clear) begin
         valid_reg <= 1'b0;
      end else if (in_ready) begin
         valid_reg <= in_valid;
         if (in_valid) begin
            data_reg <= in_data;
         end
      end
   end

endmodule

// File: rtl/trees_burst_driver.sv
// -----------------------------------------------------------------------------
// trees_burst_driver
//   Sequences one inference job on a tree accelerator: streams feature words
//   into the accelerator memory, pulses start, waits for done (with timeout),
//   then reads back predictions packed 8 per 64-bit word onto an output stream.
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     cfg_valid, cfg_burst_len    job request and its sample count
//     abort                       synchronous cancel of the running job
//     in_valid/in_ready/in_data   feature word stream (sample-major)
//     load_features, feature_addr,
//     features2, burst_len, start accelerator write/start side
//     prediction, prediction_addr,
//     done                        accelerator read side (prediction is a
//                                 combinational read of prediction_addr)
//     out_valid/out_ready/out_data packed prediction stream
//     busy, job_done, err         status (job_done/err are one-cycle pulses)
// -----------------------------------------------------------------------------
module trees_burst_driver
   import trees_pkg::*;
#(
   parameter int N_FEATURE      = 32,
   parameter int MAX_BURST      = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   cfg_valid,
   input  logic [len_w(MAX_BURST)-1:0]            cfg_burst_len,
   input  logic                                   abort,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [63:0]                            in_data,
   output logic                                   load_features,
   output logic [faddr_w(MAX_BURST,N_FEATURE)-1:0] feature_addr,
   output logic [63:0]                            features2,
   output logic [len_w(MAX_BURST)-1:0]            burst_len,
   output logic                                   start,
   input  logic [63:0]                            prediction,
   output logic [len_w(MAX_BURST)-1:0]            prediction_addr,
   input  logic                                   done,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [63:0]                            out_data,
   output logic                                   busy,
   output logic                                   job_done,
   output logic                                   err
);

   localparam int HALF    = half_n_feature(N_FEATURE);
   localparam int HALF_SH = $clog2(HALF);
   localparam int LEN_W   = len_w(MAX_BURST);
   localparam int FADDR_W = faddr_w(MAX_BURST, N_FEATURE);
   localparam int CNT_W   = cnt_w(MAX_BURST, N_FEATURE);
   localparam int TMO_W   = tmo_w(TIMEOUT_CYCLES);

   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BURST);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t             state_reg, state_next;
   logic [LEN_W-1:0]   burst_len_reg;
   logic [CNT_W-1:0]   total_reg;      // feature words expected this job
   logic [CNT_W-1:0]   wr_cnt_reg;
   logic               load_features_reg;
   logic [63:0]        features2_reg;
   logic [FADDR_W-1:0] feature_addr_reg;
   logic [TMO_W-1:0]   tmo_cnt_reg;
   logic [LEN_W-1:0]   rd_idx_reg;
   logic [LEN_W-1:0]   hs_cnt_reg;     // output handshakes completed

   logic [CNT_W-1:0]   cfg_total;
   logic [LEN_W-1:0]   nw;
   logic               len_ok;
   logic               accept;
   logic               wr_fire;
   logic               drain_load;
   logic               abort_hit;
   logic               skid_in_ready;
   logic               out_fire;

   // Words per job = samples * HALF; a shift when HALF is a power of two.
   generate
      if ((1 << HALF_SH) == HALF) begin : g_total_shift
         assign cfg_total = CNT_W'(cfg_burst_len) << HALF_SH;
      end else begin : g_total_mul
         assign cfg_total = CNT_W'(cfg_burst_len) * CNT_W'(HALF);
      end
   endgenerate

   // Output words = ceil(samples / 8).
   assign nw        = (burst_len_reg + LEN_W'(7)) >> 3;
   assign len_ok    = (cfg_burst_len != '0) && (cfg_burst_len <= MAX_LEN);
   assign abort_hit = abort && (state_reg != IDLE);
   assign out_fire  = out_valid && out_ready;

   assign busy            = (state_reg != IDLE);
   assign burst_len       = burst_len_reg;
   assign load_features   = load_features_reg;
   assign features2       = features2_reg;
   assign feature_addr    = feature_addr_reg;
   assign prediction_addr = rd_idx_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      start      = 1'b0;
      err        = 1'b0;
      job_done   = 1'b0;
      accept     = 1'b0;
      wr_fire    = 1'b0;
      drain_load = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cfg_valid) begin
               if (len_ok) begin
                  accept     = 1'b1;
                  state_next = LOAD;
               end else begin
                  err = 1'b1;
               end
            end
         end
         LOAD: begin
            in_ready = (wr_cnt_reg < total_reg) && !abort;
            wr_fire  = in_valid && in_ready;
            // The last write is issued in the cycle the count reaches total.
            if (wr_cnt_reg == total_reg) begin
               state_next = START;
            end
         end
         START: begin
            start      = 1'b1;
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done) begin
               state_next = DRAIN;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               err        = 1'b1;
               state_next = IDLE;
            end
         end
         DRAIN: begin
            drain_load = (rd_idx_reg < nw) && skid_in_ready;
            if (out_fire && (hs_cnt_reg == nw - LEN_W'(1))) begin
               job_done   = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (abort_hit) begin
         state_next = IDLE;
         start      = 1'b0;
         err        = 1'b0;
         job_done   = 1'b0;
         drain_load = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_len_reg     <= '0;
         total_reg         <= '0;
         wr_cnt_reg        <= '0;
         load_features_reg <= 1'b0;
         features2_reg     <= '0;
         feature_addr_reg  <= '0;
         tmo_cnt_reg       <= '0;
         rd_idx_reg        <= '0;
         hs_cnt_reg        <= '0;
      end else begin
         load_features_reg <= wr_fire;
         if (wr_fire) begin
            features2_reg    <= in_data;
            feature_addr_reg <= wr_cnt_reg[FADDR_W-1:0];
            wr_cnt_reg       <= wr_cnt_reg + CNT_W'(1);
         end
         if (state_reg == WAIT_DONE) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
         end
         if (drain_load) begin
            rd_idx_reg <= rd_idx_reg + LEN_W'(1);
         end
         if ((state_reg == DRAIN) && out_fire) begin
            hs_cnt_reg <= hs_cnt_reg + LEN_W'(1);
         end
         if (accept) begin
            burst_len_reg <= cfg_burst_len;
            total_reg     <= cfg_total;
            wr_cnt_reg    <= '0;
            tmo_cnt_reg   <= '0;
            rd_idx_reg    <= '0;
            hs_cnt_reg    <= '0;
         end
      end
   end

   trees_out_skid #(
      .W (64)
   ) u_out_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (abort_hit),
      .in_valid  (drain_load),
      .in_ready  (skid_in_ready),
      .in_data   (prediction),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

endmodule

// File: tb/tb_trees_burst_driver.sv
// -----------------------------------------------------------------------------
// tb_trees_burst_driver
//   Directed bench for trees_burst_driver: feeds feature words, plays the
//   accelerator (prediction = 0xC0DE << 48 | address, done after a delay),
//   sinks the output stream and compares against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_trees_burst_driver;

   localparam int N_FEATURE      = 32;
   localparam int MAX_BURST      = 5000;
   localparam int TIMEOUT_CYCLES = 100;
   localparam int LEN_W          = $clog2(MAX_BURST) + 1;
   localparam int FADDR_W        = $clog2(MAX_BURST * N_FEATURE / 2);

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               cfg_valid = 1'b0;
   logic [LEN_W-1:0]   cfg_burst_len = '0;
   logic               abort = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [63:0]        in_data = '0;
   logic               load_features;
   logic [FADDR_W-1:0] feature_addr;
   logic [63:0]        features2;
   logic [LEN_W-1:0]   burst_len;
   logic               start;
   logic [63:0]        prediction;
   logic [LEN_W-1:0]   prediction_addr;
   logic               done = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [63:0]        out_data;
   logic               busy;
   logic               job_done;
   logic               err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Accelerator prediction memory model.
   assign prediction = 64'hC0DE_0000_0000_0000 | 64'(prediction_addr);

   trees_burst_driver #(
      .N_FEATURE      (N_FEATURE),
      .MAX_BURST      (MAX_BURST),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cfg_valid       (cfg_valid),
      .cfg_burst_len   (cfg_burst_len),
      .abort           (abort),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .load_features   (load_features),
      .feature_addr    (feature_addr),
      .features2       (features2),
      .burst_len       (burst_len),
      .start           (start),
      .prediction      (prediction),
      .prediction_addr (prediction_addr),
      .done            (done),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .busy            (busy),
      .job_done        (job_done),
      .err             (err)
   );

   // ---------------- monitor (samples on the falling edge) ----------------
   logic [63:0] wr_addr_q[$];
   logic [63:0] wr_data_q[$];
   logic [63:0] out_q[$];
   int          cyc = 0;
   int          n_start = 0;
   int          n_err = 0;
   int          n_jd = 0;
   int          start_cyc = 0;
   int          err_cyc = 0;
   int          stall_cyc = 0;
   int          stall_chg = 0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data = '0;

   always @(negedge clk) begin
      cyc++;
      if (load_features) begin
         wr_addr_q.push_back(64'(feature_addr));
         wr_data_q.push_back(features2);
      end
      if (start) begin
         n_start++;
         start_cyc = cyc;
      end
      if (err) begin
         n_err++;
         err_cyc = cyc;
      end
      if (job_done) n_jd++;
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (out_valid && !out_ready) begin
         stall_cyc++;
         if (prev_stall && (out_data != prev_data)) stall_chg++;
         prev_stall = 1'b1;
         prev_data  = out_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pred_exp(input int k);
      return 64'hC0DE_0000_0000_0000 | 64'(k);
   endfunction

   task automatic cfg(input int len);
      @(posedge clk); #1;
      cfg_valid     = 1'b1;
      cfg_burst_len = LEN_W'(len);
      @(posedge clk); #1;
      cfg_valid     = 1'b0;
   endtask

   // Feed n words base+i; toggle inserts an idle cycle between words.
   task automatic feed(input int n, input logic [63:0] base, input bit toggle);
      int  i = 0;
      int  k = 0;
      int  budget = 4 * n + 100;
      bit  hs;
      while (i < n && k < budget) begin
         in_valid = toggle ? ((k % 2) == 0) : 1'b1;
         in_data  = base + 64'(i);
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) i++;
         k++;
      end
      in_valid = 1'b0;
      if (i < n) check("feed_timeout", 64'(i), 64'(n));
   endtask

   // Accelerator back end plus output sink for one job.
   task automatic run_back(input int delay, input int stall);
      int jd0 = n_jd;
      int k = 0;
      do begin @(negedge clk); k++; end while (!start && k < 3000);
      if (!start) begin
         check("start_timeout", 64'(0), 64'(1));
         return;
      end
      repeat (delay) @(posedge clk);
      #1 done = 1'b1;
      @(posedge clk); #1 done = 1'b0;
      if (stall > 0) begin
         k = 0;
         do begin @(negedge clk); k++; end while (!out_valid && k < 100);
         repeat (stall) @(posedge clk);
         #1 out_ready = 1'b1;
      end
      k = 0;
      while (n_jd == jd0 && k < 300) begin @(negedge clk); k++; end
      if (n_jd == jd0) check("job_done_timeout", 64'(0), 64'(1));
   endtask

   task automatic check_writes(input string tag, input int w0, input int n, input logic [63:0] base);
      check({tag, "_wr_count"}, 64'(wr_addr_q.size() - w0), 64'(n));
      for (int i = 0; i < n && (w0 + i) < wr_addr_q.size(); i++) begin
         check({tag, "_wr_addr"}, wr_addr_q[w0 + i], 64'(i));
         check({tag, "_wr_data"}, wr_data_q[w0 + i], base + 64'(i));
      end
   endtask

   task automatic check_outs(input string tag, input int o0, input int nw);
      check({tag, "_out_count"}, 64'(out_q.size() - o0), 64'(nw));
      for (int i = 0; i < nw && (o0 + i) < out_q.size(); i++) begin
         check({tag, "_out_data"}, out_q[o0 + i], pred_exp(i));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w0, o0, s0, j0, e0;
      int k;

      // Reset state.
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_load", 64'(load_features), 64'(0));
      check("rst_faddr", 64'(feature_addr), 64'(0));
      check("rst_feat", features2, 64'(0));
      check("rst_blen", 64'(burst_len), 64'(0));
      check("rst_start", 64'(start), 64'(0));
      check("rst_paddr", 64'(prediction_addr), 64'(0));
      check("rst_oval", 64'(out_valid), 64'(0));
      check("rst_odata", out_data, 64'(0));
      check("rst_jd_err", {62'd0, job_done, err}, 64'(0));
      @(posedge clk); #1 rst_n = 1'b1;

      // Job 1: one sample, back-to-back words, done after 50 cycles.
      w0 = wr_addr_q.size(); o0 = out_q.size(); s0 = n_start; j0 = n_jd;
      cfg(1);
      fork
         feed(16, 64'h1000_0000_0000_0000, 1'b0);
         run_back(50, 0);
      join
      @(negedge clk);
      check_writes("j1", w0, 16, 64'h1000_0000_0000_0000);
      check("j1_start", 64'(n_start - s0), 64'(1));
      check_outs("j1", o0, 1);
      check("j1_jd", 64'(n_jd - j0), 64'(1));
      check("j1_busy", 64'(busy), 64'(0));
      check("j1_oval", 64'(out_valid), 64'(0));
      $display("[TB] job len=1 writes=%0d outputs=%0d", wr_addr_q.size() - w0, out_q.size() - o0);

      // Job 2: nine samples, 50% in_valid duty.
      w0 = wr_addr_q.size(); o0 = out_q.size(); j0 = n_jd;
      cfg(9);
      check("j2_blen", 64'(burst_len), 64'(9));
      fork
         feed(144, 64'h2000_0000_0000_0000, 1'b1);
         run_back(20, 0);
      join
      check_writes("j2", w0, 144, 64'h2000_0000_0000_0000);
      check_outs("j2", o0, 2);
      check("j2_jd", 64'(n_jd - j0), 64'(1));
      check("j2_blen_hold", 64'(burst_len), 64'(9));
      $display("[TB] job len=9 writes=%0d outputs=%0d", wr_addr_q.size() - w0, out_q.size() - o0);

      // Job 3: sixteen samples, output stalled for 10 cycles.
      w0 = wr_addr_q.size(); o0 = out_q.size(); j0 = n_jd;
      stall_cyc = stall_cyc;
      k = stall_cyc;
      e0 = stall_chg;
      out_ready = 1'b0;
      cfg(16);
      fork
         feed(256, 64'h3000_0000_0000_0000, 1'b0);
         run_back(10, 10);
      join
      check_writes("j3", w0, 256, 64'h3000_0000_0000_0000);
      check_outs("j3", o0, 2);
      check("j3_stall_cycles", 64'(stall_cyc - k), 64'(10));
      check("j3_stall_stable", 64'(stall_chg - e0), 64'(0));
      check("j3_jd", 64'(n_jd - j0), 64'(1));
      $display("[TB] job len=16 writes=%0d outputs=%0d", wr_addr_q.size() - w0, out_q.size() - o0);

      // Illegal lengths 0 and MAX_BURST+1.
      w0 = wr_addr_q.size(); e0 = n_err;
      cfg(0);
      @(negedge clk);
      check("bad0_err", 64'(n_err - e0), 64'(1));
      check("bad0_busy", 64'(busy), 64'(0));
      cfg(MAX_BURST + 1);
      @(negedge clk);
      check("bad5001_err", 64'(n_err - e0), 64'(2));
      check("bad5001_busy", 64'(busy), 64'(0));
      check("bad_no_writes", 64'(wr_addr_q.size() - w0), 64'(0));
      $display("[TB] job len=0/5001 rejected errs=%0d", n_err - e0);

      // Timeout: done never arrives.
      e0 = n_err; j0 = n_jd;
      cfg(1);
      feed(16, 64'h4000_0000_0000_0000, 1'b0);
      k = 0;
      while (n_err == e0 && k < 400) begin @(negedge clk); k++; end
      check("tmo_err", 64'(n_err - e0), 64'(1));
      check("tmo_cycle", 64'(err_cyc - start_cyc), 64'(TIMEOUT_CYCLES));
      @(negedge clk);
      check("tmo_busy", 64'(busy), 64'(0));
      check("tmo_no_jd", 64'(n_jd - j0), 64'(0));
      $display("[TB] job len=1 timeout after %0d cycles", err_cyc - start_cyc);

      // Abort in LOAD after 5 words, then a clean two-sample job.
      j0 = n_jd;
      cfg(3);
      feed(5, 64'h5000_0000_0000_0000, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      check("abort_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_load", 64'(load_features), 64'(0));
      check("abort_no_jd", 64'(n_jd - j0), 64'(0));
      w0 = wr_addr_q.size(); o0 = out_q.size();
      cfg(2);
      fork
         feed(32, 64'h6000_0000_0000_0000, 1'b0);
         run_back(5, 0);
      join
      check_writes("j6", w0, 32, 64'h6000_0000_0000_0000);
      check_outs("j6", o0, 1);
      check("j6_jd", 64'(n_jd - j0), 64'(1));
      $display("[TB] job len=2 after abort writes=%0d outputs=%0d", wr_addr_q.size() - w0, out_q.size() - o0);

      // Reset mid-job; the first cycle after release accepts a new job.
      cfg(4);
      feed(3, 64'h7000_0000_0000_0000, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_blen", 64'(burst_len), 64'(0));
      rst_n         = 1'b1;
      cfg_valid     = 1'b1;
      cfg_burst_len = LEN_W'(7);
      @(posedge clk); #1 cfg_valid = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'(1));
      check("post_rst_blen", 64'(burst_len), 64'(7));
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("post_rst_abort", 64'(busy), 64'(0));
      $display("[TB] reset mid-job, new job accepted len=%0d", burst_len);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trees_burst_driver.md
TREES_BURST_DRIVER -- requirements
Module: trees_burst_driver

Interface
REQ-001 SHALL have parameter N_FEATURE, default 32: features per sample; 32-bit features packed two per 64-bit word, giving HALF_N_FEATURE = N_FEATURE/2 words per sample.
REQ-002 SHALL have parameter MAX_BURST, default 5000: maximum samples per job.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum cycles spent in WAIT_DONE.
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: cfg_valid  in  1  job request; cfg_burst_len  in  $clog2(MAX_BURST)+1  samples in job; abort  in  1  synchronous job cancel.
REQ-006 SHALL have ports: in_valid  in  1, in_ready  out  1, in_data  in  64: feature word stream, sample-major.
REQ-007 SHALL have ports: load_features  out  1, feature_addr  out  $clog2(MAX_BURST*N_FEATURE/2), features2  out  64, burst_len  out  $clog2(MAX_BURST)+1, start  out  1: accelerator write/start side.
REQ-008 SHALL have ports: prediction  in  64 (combinational read of prediction_addr), prediction_addr  out  $clog2(MAX_BURST)+1, done  in  1 (one-cycle pulse): accelerator read side.
REQ-009 SHALL have ports: out_valid  out  1, out_ready  in  1, out_data  out  64: packed predictions, 8 x 8-bit per word, sample 8k+j in byte j.
REQ-010 SHALL have ports: busy  out  1, job_done  out  1, err  out  1 (one-cycle pulses for job_done and err).

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, START, WAIT_DONE, DRAIN.
REQ-012 IDLE: on cfg_valid with 1 <= cfg_burst_len <= MAX_BURST, SHALL latch the length into burst_len, clear counters, and enter LOAD; otherwise it SHALL pulse err and remain in IDLE.
REQ-013 burst_len SHALL stay stable from acceptance until the next accepted job.
REQ-014 LOAD: in_ready SHALL be 1; each in_valid&in_ready SHALL, on the next cycle, drive load_features=1, features2=in_data, feature_addr=wr_cnt; wr_cnt SHALL increment per handshake.
REQ-015 After handshake number burst_len*HALF_N_FEATURE, in_ready SHALL drop the following cycle and the FSM SHALL enter START once the final load_features write has been issued.
REQ-016 load_features SHALL be 0 whenever no write is issued; in_valid gaps SHALL insert idle cycles with no write.
REQ-017 START: start SHALL be 1 for exactly one cycle, then the FSM SHALL enter WAIT_DONE.
REQ-018 WAIT_DONE: on done=1, the FSM SHALL enter DRAIN; a timeout counter reaching TIMEOUT_CYCLES SHALL pulse err and return to IDLE.
REQ-019 DRAIN: SHALL produce NW = ceil(burst_len/8) words; prediction_addr = rd_idx; when out_valid=0 or out_ready=1, the block SHALL register out_data<=prediction, set out_valid=1, and increment rd_idx while rd_idx < NW.
REQ-020 out_data/out_valid SHALL hold while out_valid&!out_ready; no word SHALL be dropped or duplicated.
REQ-021 After the NW-th output handshake, the block SHALL pulse job_done, deassert out_valid, and return to IDLE.
REQ-022 Last-word bytes beyond burst_len SHALL be passed as read, with no masking.
REQ-023 busy SHALL be 1 in every state except IDLE; cfg_valid SHALL be ignored while busy.
REQ-024 abort (any non-IDLE state) SHALL return the FSM to IDLE the next cycle, drop in_ready/out_valid/load_features/start, and not pulse job_done; a done arriving in IDLE SHALL be ignored.
REQ-025 Counters SHALL be sized for MAX_BURST*HALF_N_FEATURE without wrap; wr_cnt*8 arithmetic SHALL use shifts, not multipliers.

Reset
REQ-026 On reset, the FSM SHALL be IDLE and all outputs 0, including burst_len, feature_addr, features2, prediction_addr, and out_data.
REQ-027 Reset mid-job SHALL discard the job; the first post-reset cycle SHALL accept cfg_valid.

Structure
REQ-028 A shared package trees_pkg SHALL hold the FSM state typedef and the HALF_N_FEATURE/width localparam functions.
REQ-029 The output register SHALL be one sub-module, trees_out_skid, with 64-bit data and a valid/ready pass-through register.

Verification
REQ-030 burst_len=1, 16 words 0..15 back-to-back: feature_addr 0..15 carry the data, one start pulse, done after 50 cycles, 1 output word = prediction[0], job_done x1.
REQ-031 burst_len=9, in_valid toggling 50%: 144 writes in order, 2 output words from prediction_addr 0,1.
REQ-032 burst_len=16, out_ready low for 10 cycles then high: out_data stable while stalled, 2 words, no duplicates.
REQ-033 cfg_burst_len=0 and =5001: err pulse each, busy stays 0, no load_features.
REQ-034 done withheld, TIMEOUT_CYCLES=100: err at cycle 100 of WAIT_DONE, return to IDLE.
REQ-035 abort in LOAD after 5 words, then a new burst_len=2 job: writes restart at feature_addr 0, job completes normally.
